// File: rtl/ex_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: default width and FSM state encoding.
package ex_div_ctrl_pkg;

    localparam int unsigned DIV_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ex_div_ctrl_if.sv
// Request/result bundle between the ID/EX pipeline (master) and the divide sequencer (slave).
interface ex_div_ctrl_if
    import ex_div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) ();

    logic                  start;
    logic                  signed_op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  cancel;
    logic                  stall_req;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_zero;

    modport master (
        output start, signed_op, dividend, divisor, cancel,
        input  stall_req, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor, cancel,
        output stall_req, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// One combinational radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and shift the outcome into the quotient.
module ex_div_ctrl_div_step
    import ex_div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic [DATA_WIDTH-1:0] q_out
);

    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  fits;

    always_comb begin
        shifted = {rem_in, q_in[DATA_WIDTH-1]};
        fits    = shifted >= {2'b00, divisor};
        diff    = shifted[DATA_WIDTH:0] - {1'b0, divisor};
        rem_out = fits ? diff : shifted[DATA_WIDTH:0];
        q_out   = {q_in[DATA_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: holds the pipeline while a restoring divide runs on
// operand magnitudes, then applies the sign fix and presents quotient/remainder for HI/LO.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    div_state_t state, state_next;

    logic                  accept;
    logic                  last_step;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH:0]   rem;
    logic [DATA_WIDTH-1:0] q_shift;
    logic [DATA_WIDTH-1:0] dvs;
    logic                  neg_q;
    logic                  neg_r;
    logic [DATA_WIDTH:0]   step_rem;
    logic [DATA_WIDTH-1:0] step_q;
    logic [DATA_WIDTH-1:0] dividend_abs;
    logic [DATA_WIDTH-1:0] divisor_abs;
    logic [DATA_WIDTH-1:0] q_fixed;
    logic [DATA_WIDTH-1:0] r_fixed;

    ex_div_ctrl_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_in  (rem),
        .q_in    (q_shift),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        bus.stall_req = 1'b0;
        bus.done      = 1'b0;
        last_step     = (count == LAST_STEP);
        if (bus.cancel) begin
            state_next = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE, DIV_DONE: begin
                    if (bus.start) begin
                        accept     = 1'b1;
                        state_next = (bus.divisor == '0) ? DIV_DONE : DIV_RUN;
                    end else begin
                        state_next = DIV_IDLE;
                    end
                end
                DIV_RUN:  if (last_step) state_next = DIV_DONE;
                default:  state_next = DIV_IDLE;
            endcase
        end
        // Stall drops in the DONE cycle so the pipeline advances with the done pulse.
        bus.stall_req = accept | ((state == DIV_RUN) & ~bus.cancel);
        bus.done      = (state == DIV_DONE);
    end

    always_comb begin
        dividend_abs = (bus.signed_op & bus.dividend[DATA_WIDTH-1]) ? ('0 - bus.dividend) : bus.dividend;
        divisor_abs  = (bus.signed_op & bus.divisor[DATA_WIDTH-1])  ? ('0 - bus.divisor)  : bus.divisor;
        q_fixed      = neg_q ? ('0 - step_q) : step_q;
        r_fixed      = neg_r ? ('0 - step_rem[DATA_WIDTH-1:0]) : step_rem[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            rem           <= '0;
            q_shift       <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b0;
        end else if (accept) begin
            if (bus.divisor == '0) begin
                bus.quotient  <= '0;
                bus.remainder <= '0;
                bus.div_zero  <= 1'b1;
            end else begin
                count   <= '0;
                rem     <= '0;
                q_shift <= dividend_abs;
                dvs     <= divisor_abs;
                neg_q   <= bus.signed_op & (bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1]);
                neg_r   <= bus.signed_op & bus.dividend[DATA_WIDTH-1];
            end
        end else if ((state == DIV_RUN) && !bus.cancel) begin
            rem     <= step_rem;
            q_shift <= step_q;
            count   <= count + 1'b1;
            // Final iteration result is sign-fixed straight into the output registers.
            if (last_step) begin
                bus.quotient  <= q_fixed;
                bus.remainder <= r_fixed;
                bus.div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed corner cases plus random operations
// compared against a plain-arithmetic division model.
module tb_ex_div_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_z = 1'b0;

    always #5 clk = ~clk;

    ex_div_ctrl_if #(.DATA_WIDTH(32)) bus ();

    ex_div_ctrl #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint la, lb;
        if (b == 32'd0) begin
            q = '0; r = '0; z = 1'b1;
        end else begin
            if (sgn) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            q = 32'(la / lb);
            r = 32'(la % lb);
            z = 1'b0;
        end
    endfunction

    // Called just after a negedge; returns the cycle offset of done relative to the accept cycle.
    task automatic wait_done(output int lat, output int stalls);
        lat    = 0;
        stalls = 0;
        for (int k = 1; k <= 100; k++) begin
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            stalls += int'(bus.stall_req);
            @(negedge clk);
        end
    endtask

    task automatic finish_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        int          lat, stalls;
        ref_div(sgn, a, b, eq, er, ez);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, stalls);
        check({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
        check({tag, " stall_cycles"}, 32'(stalls), (b == 32'd0) ? 32'd0 : 32'd32);
        check({tag, " stall_in_done"}, 32'(bus.stall_req), 32'd0);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_zero"}, 32'(bus.div_zero), 32'(ez));
        last_q = eq; last_r = er; last_z = ez;
        @(negedge clk);
        #1 check({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        #1 check({tag, " stall_on_accept"}, 32'(bus.stall_req), 32'd1);
        finish_op(tag, sgn, a, b);
    endtask

    initial begin
        int lat, stalls, done_seen, sel;
        logic        rs;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset done", 32'(bus.done), 32'd0);
        check("reset stall_req", 32'(bus.stall_req), 32'd0);
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset div_zero", 32'(bus.div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("divu_3_max", 1'b0, 32'd3, 32'hFFFF_FFFF);

        // Cancel at RUN cycle 10: no done, results from the previous op retained.
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1234567; bus.divisor = 32'd89;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        #1 check("cancel stall_forced_low", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        bus.cancel = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            done_seen += int'(bus.done) + int'(bus.stall_req);
            @(negedge clk);
        end
        check("cancel no_done_no_stall", 32'(done_seen), 32'd0);
        check("cancel quotient_kept", bus.quotient, last_q);
        check("cancel remainder_kept", bus.remainder, last_r);
        check("cancel div_zero_kept", 32'(bus.div_zero), 32'(last_z));

        run_op("after_cancel", 1'b1, 32'hFFFF_FF00, 32'd10);

        // Reset at RUN cycle 10 discards the op and clears outputs.
        bus.start = 1'b1; bus.signed_op = 1'b1; bus.dividend = 32'h7654_3210; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst quotient", bus.quotient, 32'd0);
        check("midrst remainder", bus.remainder, 32'd0);
        check("midrst div_zero", 32'(bus.div_zero), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst stall_req", 32'(bus.stall_req), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1 done_seen += int'(bus.done);
        end
        check("midrst no_done", 32'(done_seen), 32'd0);
        @(negedge clk);

        // Start held through RUN is ignored; start in the DONE cycle launches a back-to-back op.
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd33;
        #1 check("held stall_on_accept", 32'(bus.stall_req), 32'd1);
        lat = 0; stalls = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            stalls += int'(bus.stall_req);
            bus.signed_op = 1'($urandom_range(0, 1));
            bus.dividend  = $urandom;
            bus.divisor   = $urandom;
        end
        check("held latency", 32'(lat), 32'd33);
        check("held stall_cycles", 32'(stalls), 32'd32);
        check("held quotient", bus.quotient, 32'd30);
        check("held remainder", bus.remainder, 32'd10);
        bus.signed_op = 1'b1; bus.dividend = 32'hFFFF_FC18; bus.divisor = 32'd7;
        #1 check("b2b stall_on_accept", 32'(bus.stall_req), 32'd1);
        finish_op("b2b", 1'b1, 32'hFFFF_FC18, 32'd7);

        for (int i = 0; i < 10; i++) begin
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = $urandom;
                default: rb = 32'd0 - 32'($urandom_range(1, 9));
            endcase
            run_op($sformatf("rand%0d", i), rs, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
